// File: rtl/ps2_mouse_packet_decoder_pkg.sv
// Shared types and constants for the PS/2 mouse packet decoder and the downstream accumulator.
package ps2_mouse_pkg;

    typedef enum logic [2:0] {
        SEND,
        WAIT_TX,
        WAIT_ACK,
        B1,
        B2,
        B3
    } state_t;

    localparam logic [7:0] CMD_ENABLE = 8'hF4;
    localparam logic [7:0] RSP_ACK    = 8'hFA;

    localparam int unsigned B1_L    = 0;
    localparam int unsigned B1_R    = 1;
    localparam int unsigned B1_M    = 2;
    localparam int unsigned B1_SYNC = 3;
    localparam int unsigned B1_XS   = 4;
    localparam int unsigned B1_YS   = 5;
    localparam int unsigned B1_XO   = 6;
    localparam int unsigned B1_YO   = 7;

    typedef logic [8:0] delta_t;

    // An overflowed axis clamps to the extreme of its sign instead of wrapping.
    function automatic delta_t form_delta(input logic sign, input logic ovf, input logic [7:0] mag);
        if (ovf)
            return sign ? 9'h100 : 9'h0FF;
        else
            return {sign, mag};
    endfunction

endpackage

// File: rtl/ps2_mouse_packet_decoder_if.sv
// Byte-PHY and accumulator-facing signals of the mouse packet decoder.
interface ps2_mouse_packet_decoder_if;
    import ps2_mouse_pkg::*;

    logic [7:0] rx_data_i;
    logic       rx_valid_i;
    logic       rx_err_i;
    logic [7:0] tx_data_o;
    logic       tx_start_o;
    logic       tx_done_i;
    delta_t     xm_o;
    delta_t     ym_o;
    logic [2:0] btnm_o;
    logic       m_done_tick_o;
    logic       init_done_o;
    logic       init_fail_o;
    logic       pkt_err_o;

    // Decoder side
    modport master (
        input  rx_data_i, rx_valid_i, rx_err_i, tx_done_i,
        output tx_data_o, tx_start_o, xm_o, ym_o, btnm_o,
               m_done_tick_o, init_done_o, init_fail_o, pkt_err_o
    );

    // PHY / accumulator side
    modport slave (
        output rx_data_i, rx_valid_i, rx_err_i, tx_done_i,
        input  tx_data_o, tx_start_o, xm_o, ym_o, btnm_o,
               m_done_tick_o, init_done_o, init_fail_o, pkt_err_o
    );

endinterface

// File: rtl/ps2_mouse_packet_decoder.sv
// Enables PS/2 mouse streaming, then assembles 3-byte movement packets into deltas and buttons.
module ps2_mouse_packet_decoder
    import ps2_mouse_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC  = 1_000_000,
    parameter int unsigned INIT_RETRIES = 3
) (
    input logic                         clk_i,
    input logic                         rst_i,
    ps2_mouse_packet_decoder_if.master  bus
);

    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned RW = $clog2(INIT_RETRIES + 1);

    state_t        r_state, w_state_next;
    logic [TW-1:0] r_tmo, w_tmo_next;
    logic [RW-1:0] r_retry, w_retry_next;
    logic [7:0]    r_b1, w_b1_next;
    logic [7:0]    r_b2, w_b2_next;
    logic [7:0]    r_tx_data, w_tx_data_next;
    logic          r_tx_start, w_tx_start_next;
    delta_t        r_xm, w_xm_next;
    delta_t        r_ym, w_ym_next;
    logic [2:0]    r_btn, w_btn_next;
    logic          r_tick, w_tick_next;
    logic          r_init_done, w_init_done_next;
    logic          r_init_fail, w_init_fail_next;
    logic          r_pkt_err, w_pkt_err_next;

    logic          w_tmo_hit;
    logic          w_byte;
    logic [RW-1:0] w_retry_inc;

    // Error wins over a simultaneous valid byte
    assign w_byte      = bus.rx_valid_i && !bus.rx_err_i;
    assign w_tmo_hit   = (r_tmo >= TW'(TIMEOUT_CYC - 1));
    assign w_retry_inc = r_retry + RW'(1);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= SEND;
            r_tmo       <= '0;
            r_retry     <= '0;
            r_b1        <= '0;
            r_b2        <= '0;
            r_tx_data   <= '0;
            r_tx_start  <= 1'b0;
            r_xm        <= '0;
            r_ym        <= '0;
            r_btn       <= '0;
            r_tick      <= 1'b0;
            r_init_done <= 1'b0;
            r_init_fail <= 1'b0;
            r_pkt_err   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_tmo       <= w_tmo_next;
            r_retry     <= w_retry_next;
            r_b1        <= w_b1_next;
            r_b2        <= w_b2_next;
            r_tx_data   <= w_tx_data_next;
            r_tx_start  <= w_tx_start_next;
            r_xm        <= w_xm_next;
            r_ym        <= w_ym_next;
            r_btn       <= w_btn_next;
            r_tick      <= w_tick_next;
            r_init_done <= w_init_done_next;
            r_init_fail <= w_init_fail_next;
            r_pkt_err   <= w_pkt_err_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_retry_next     = r_retry;
        w_b1_next        = r_b1;
        w_b2_next        = r_b2;
        w_tx_data_next   = r_tx_data;
        w_tx_start_next  = 1'b0;
        w_xm_next        = r_xm;
        w_ym_next        = r_ym;
        w_btn_next       = r_btn;
        w_tick_next      = 1'b0;
        w_init_done_next = r_init_done;
        w_init_fail_next = r_init_fail;
        w_pkt_err_next   = 1'b0;

        case (r_state)
            SEND: begin
                w_tx_data_next  = CMD_ENABLE;
                w_tx_start_next = 1'b1;
                w_state_next    = WAIT_TX;
            end
            WAIT_TX: begin
                if (bus.tx_done_i)
                    w_state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (w_byte && bus.rx_data_i == RSP_ACK) begin
                    w_init_done_next = 1'b1;
                    w_state_next     = B1;
                end else if (bus.rx_err_i || bus.rx_valid_i || w_tmo_hit) begin
                    w_retry_next = w_retry_inc;
                    if (w_retry_inc < RW'(INIT_RETRIES)) begin
                        w_state_next = SEND;
                    end else begin
                        w_init_fail_next = 1'b1;
                        w_state_next     = B1;
                    end
                end
            end
            B1: begin
                if (bus.rx_err_i) begin
                    w_pkt_err_next = 1'b1;
                end else if (bus.rx_valid_i) begin
                    if (bus.rx_data_i[B1_SYNC]) begin
                        w_b1_next    = bus.rx_data_i;
                        w_state_next = B2;
                    end else begin
                        w_pkt_err_next = 1'b1;
                    end
                end
            end
            B2: begin
                if (bus.rx_err_i) begin
                    w_pkt_err_next = 1'b1;
                    w_state_next   = B1;
                end else if (bus.rx_valid_i) begin
                    w_b2_next    = bus.rx_data_i;
                    w_state_next = B3;
                end else if (w_tmo_hit) begin
                    w_pkt_err_next = 1'b1;
                    w_state_next   = B1;
                end
            end
            B3: begin
                if (bus.rx_err_i) begin
                    w_pkt_err_next = 1'b1;
                    w_state_next   = B1;
                end else if (bus.rx_valid_i) begin
                    w_xm_next    = form_delta(r_b1[B1_XS], r_b1[B1_XO], r_b2);
                    w_ym_next    = form_delta(r_b1[B1_YS], r_b1[B1_YO], bus.rx_data_i);
                    w_btn_next   = {r_b1[B1_M], r_b1[B1_R], r_b1[B1_L]};
                    w_tick_next  = 1'b1;
                    w_state_next = B1;
                end else if (w_tmo_hit) begin
                    w_pkt_err_next = 1'b1;
                    w_state_next   = B1;
                end
            end
            default: w_state_next = SEND;
        endcase
    end

    // Cleared on any received byte or state change; otherwise counts up and holds at the top
    always_comb begin
        if (w_state_next != r_state || bus.rx_valid_i || bus.rx_err_i)
            w_tmo_next = '0;
        else if (r_tmo == TW'(TIMEOUT_CYC))
            w_tmo_next = r_tmo;
        else
            w_tmo_next = r_tmo + TW'(1);
    end

    assign bus.tx_data_o     = r_tx_data;
    assign bus.tx_start_o    = r_tx_start;
    assign bus.xm_o          = r_xm;
    assign bus.ym_o          = r_ym;
    assign bus.btnm_o        = r_btn;
    assign bus.m_done_tick_o = r_tick;
    assign bus.init_done_o   = r_init_done;
    assign bus.init_fail_o   = r_init_fail;
    assign bus.pkt_err_o     = r_pkt_err;

endmodule

// File: tb/tb_ps2_mouse_packet_decoder.sv
// Self-checking bench: packet table with a tick-driven scoreboard plus init, resync, timeout and retry sequences.
module tb_ps2_mouse_packet_decoder;
    import ps2_mouse_pkg::*;

    localparam int unsigned T = 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ps2_mouse_packet_decoder_if u_if ();

    ps2_mouse_packet_decoder #(
        .TIMEOUT_CYC  (T),
        .INIT_RETRIES (3)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (u_if.master)
    );

    typedef struct {
        logic [7:0] b1, b2, b3;
        logic [8:0] xm, ym;
        logic [2:0] btn;
    } vec_t;

    typedef struct {
        logic [8:0] xm, ym;
        logic [2:0] btn;
    } exp_t;

    exp_t sb[$];
    int   n_pass   = 0;
    int   n_chk    = 0;
    int   tick_cnt = 0;
    int   err_cnt  = 0;
    int   tx_cnt   = 0;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (u_if.m_done_tick_o) begin
                exp_t e;
                tick_cnt++;
                if (sb.size() == 0) begin
                    check("unexpected_tick", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("xm", u_if.xm_o, e.xm);
                    check("ym", u_if.ym_o, e.ym);
                    check("btnm", u_if.btnm_o, e.btn);
                end
            end
            if (u_if.tx_start_o) begin
                tx_cnt++;
                check("tx_data", u_if.tx_data_o, 8'hF4);
            end
            if (u_if.pkt_err_o) err_cnt++;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        u_if.rx_data_i  = '0;
        u_if.rx_valid_i = 1'b0;
        u_if.rx_err_i   = 1'b0;
        u_if.tx_done_i  = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_tx_start", u_if.tx_start_o, 0);
        check("rst_tx_data", u_if.tx_data_o, 0);
        check("rst_xm", u_if.xm_o, 0);
        check("rst_ym", u_if.ym_o, 0);
        check("rst_btnm", u_if.btnm_o, 0);
        check("rst_tick", u_if.m_done_tick_o, 0);
        check("rst_init_done", u_if.init_done_o, 0);
        check("rst_init_fail", u_if.init_fail_o, 0);
        check("rst_pkt_err", u_if.pkt_err_o, 0);
        tick_cnt = 0;
        err_cnt  = 0;
        tx_cnt   = 0;
        sb.delete();
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic err);
        @(posedge clk);
        #1;
        u_if.rx_data_i  = d;
        u_if.rx_valid_i = 1'b1;
        u_if.rx_err_i   = err;
        @(posedge clk);
        #1;
        u_if.rx_valid_i = 1'b0;
        u_if.rx_err_i   = 1'b0;
    endtask

    task automatic send_pkt(input vec_t v);
        exp_t e;
        send_byte(v.b1, 1'b0);
        send_byte(v.b2, 1'b0);
        e.xm  = v.xm;
        e.ym  = v.ym;
        e.btn = v.btn;
        sb.push_back(e);
        send_byte(v.b3, 1'b0);
    endtask

    task automatic wait_tx(input int target);
        for (int i = 0; i < 200 && tx_cnt < target; i++) @(negedge clk);
        check("tx_start_count", tx_cnt, target);
    endtask

    task automatic pulse_done();
        @(posedge clk);
        #1 u_if.tx_done_i = 1'b1;
        @(posedge clk);
        #1 u_if.tx_done_i = 1'b0;
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        vec_t v;
        int   e0, t0;

        // 0x19 has Y sign clear, so byte 3 = 0xFE decodes to +254; 0x39 gives the -2 case.
        vecs[0] = '{8'h19, 8'h05, 8'hFE, 9'h105, 9'h0FE, 3'b001};
        vecs[1] = '{8'h39, 8'h05, 8'hFE, 9'h105, 9'h1FE, 3'b001};
        vecs[2] = '{8'h48, 8'h12, 8'h34, 9'h0FF, 9'h034, 3'b000};
        vecs[3] = '{8'h08, 8'h01, 8'h02, 9'h001, 9'h002, 3'b000};
        vecs[4] = '{8'h9F, 8'h80, 8'h00, 9'h180, 9'h0FF, 3'b111};
        vecs[5] = '{8'hFA, 8'h00, 8'h7F, 9'h100, 9'h100, 3'b010};
        vecs[6] = '{8'h2C, 8'h7F, 8'h80, 9'h07F, 9'h180, 3'b100};

        do_reset();

        wait_tx(1);
        pulse_done();
        send_byte(RSP_ACK, 1'b0);
        settle();
        check("init_done", u_if.init_done_o, 1);
        check("init_fail_after_ack", u_if.init_fail_o, 0);
        check("single_tx_start", tx_cnt, 1);

        for (int unsigned i = 0; i < 7; i++) send_pkt(vecs[i]);
        settle();
        check("table_ticks", tick_cnt, 7);
        check("table_sb_empty", sb.size(), 0);

        e0 = err_cnt; t0 = tick_cnt;
        send_byte(8'h00, 1'b0);
        v = '{8'h08, 8'h01, 8'h02, 9'h001, 9'h002, 3'b000};
        send_pkt(v);
        settle();
        check("resync_err", err_cnt - e0, 1);
        check("resync_tick", tick_cnt - t0, 1);

        e0 = err_cnt; t0 = tick_cnt;
        send_byte(8'h08, 1'b1);
        v = '{8'h09, 8'h10, 8'h20, 9'h010, 9'h020, 3'b001};
        send_pkt(v);
        settle();
        check("b1_rxerr_err", err_cnt - e0, 1);
        check("b1_rxerr_tick", tick_cnt - t0, 1);

        e0 = err_cnt; t0 = tick_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h55, 1'b1);
        settle();
        check("b2_err_wins", err_cnt - e0, 1);
        check("b2_err_xm_hold", u_if.xm_o, 9'h010);
        v = '{8'h2B, 8'hFF, 8'h01, 9'h0FF, 9'h101, 3'b011};
        send_pkt(v);
        settle();
        check("b2_err_tick", tick_cnt - t0, 1);

        e0 = err_cnt; t0 = tick_cnt;
        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b0);
        repeat (T - 3) @(posedge clk);
        @(negedge clk);
        check("timeout_not_early", err_cnt - e0, 0);
        repeat (8) @(negedge clk);
        check("timeout_err", err_cnt - e0, 1);
        check("timeout_no_tick", tick_cnt - t0, 0);
        check("timeout_ym_hold", u_if.ym_o, 9'h101);
        v = '{8'h18, 8'h03, 8'h04, 9'h103, 9'h004, 3'b000};
        send_pkt(v);
        settle();
        check("timeout_next_tick", tick_cnt - t0, 1);

        send_byte(8'h08, 1'b0);
        send_byte(8'h01, 1'b0);
        do_reset();

        wait_tx(1);
        pulse_done();
        send_byte(8'hAA, 1'b0);
        wait_tx(2);
        pulse_done();
        repeat (T + 5) @(posedge clk);
        wait_tx(3);
        pulse_done();
        repeat (3 * T) @(posedge clk);
        @(negedge clk);
        check("retry_tx_total", tx_cnt, 3);
        check("init_fail", u_if.init_fail_o, 1);
        check("init_done_after_fail", u_if.init_done_o, 0);
        check("no_tick_after_reset", tick_cnt, 0);
        v = '{8'h0D, 8'h01, 8'h02, 9'h001, 9'h002, 3'b101};
        send_pkt(v);
        settle();
        check("fail_still_decodes", tick_cnt, 1);
        check("fail_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
